mem_port_arbiter: RTL and testbench

- Shares the single-port syn_mem between up to NUM_REQ requesters. Default mapping: 0 = meas pair reader, 1 = BCH encoder writer, 2 = BCH decoder ECC reader, 3 = external/test port.
- Replaces the hard-wired priority address mux in the top level. Grants are round-robin with a burst cap, so no requester monopolises the memory.
- Forwards the granted requester's address, write enable and write data to the memory. Tags synchronous read returns back to the owner.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_rr_pick.sv | 31 +++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the syn_mem port arbiter.
// - Requester index constants for the default requester mapping.
// - Arbiter FSM state encoding.
// - Lane offset helper for the packed per-requester address/data buses.
package mem_port_arbiter_pkg;

  localparam int unsigned REQ_MEAS = 0;
  localparam int unsigned REQ_ENC  = 1;
  localparam int unsigned REQ_DEC  = 2;
  localparam int unsigned REQ_EXT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_YIELD = 2'd2
  } arb_state_t;

  // Requester idx occupies bus bits [idx*width +: width].
  function automatic int unsigned lane_lsb(input int unsigned idx,
                                           input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index searched first; the search wraps modulo NUM_REQ
//   pick  - one-hot winner (all zero when no request)
//   valid - high when any request is set
module mem_port_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PTR_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   pick,
  output logic                 valid
);

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      int unsigned idx;
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port syn_mem between NUM_REQ
// requesters, with a burst cap so no requester monopolises the memory.
// Ports:
//   I_clk, I_rst_n           - clock, asynchronous active-low reset
//   I_req, I_wen             - per-requester request / write enable
//   I_addr, I_wdata          - packed per-requester address / write data
//   O_gnt                    - registered one-hot grant
//   O_rvalid, O_rdata        - tagged read-return strobe, broadcast data
//   O_mem_addr/_wen/_wdata   - memory-side access from the owner
//   I_mem_rdata              - memory read data (1-cycle synchronous)
//   O_busy                   - any grant held
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned BURST_CNT_WIDTH = 5
) (
  input  logic                            I_clk,
  input  logic                            I_rst_n,
  input  logic [NUM_REQ-1:0]              I_req,
  input  logic [NUM_REQ-1:0]              I_wen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   I_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   I_wdata,
  output logic [NUM_REQ-1:0]              O_gnt,
  output logic [NUM_REQ-1:0]              O_rvalid,
  output logic [DATA_WIDTH-1:0]           O_rdata,
  output logic [ADDR_WIDTH-1:0]           O_mem_addr,
  output logic                            O_mem_wen,
  output logic [DATA_WIDTH-1:0]           O_mem_wdata,
  input  logic [DATA_WIDTH-1:0]           I_mem_rdata,
  output logic                            O_busy
);

  localparam int unsigned PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BURST_CNT_WIDTH-1:0] BURST_MAX = BURST_CNT_WIDTH'(MAX_BURST);
  localparam logic [PTR_WIDTH-1:0]       LAST_IDX  = PTR_WIDTH'(NUM_REQ - 1);

  arb_state_t                 state, state_next;
  logic [NUM_REQ-1:0]         gnt, gnt_next;
  logic [NUM_REQ-1:0]         rvalid, rvalid_next;
  logic [PTR_WIDTH-1:0]       ptr, ptr_next;
  logic [BURST_CNT_WIDTH-1:0] cnt, cnt_next, cnt_inc;

  logic [NUM_REQ-1:0]         pick;
  logic                       pick_valid;
  logic [NUM_REQ-1:0]         active;
  logic                       access;
  logic                       other_pending;
  logic [PTR_WIDTH-1:0]       owner, owner_succ;

  mem_port_arbiter_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_rr_pick (
    .req   (I_req),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign active        = gnt & I_req;
  assign access        = |active;
  assign other_pending = |(I_req & ~gnt);

  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) owner = PTR_WIDTH'(i);
    end
  end

  assign owner_succ = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  // Saturates at the cap so a lone owner keeps its grant indefinitely.
  assign cnt_inc    = (cnt == BURST_MAX) ? cnt : cnt + 1'b1;

  // State register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      ptr    <= '0;
      cnt    <= '0;
      rvalid <= '0;
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
      ptr    <= ptr_next;
      cnt    <= cnt_next;
      rvalid <= rvalid_next;
    end
  end

  // Next-state logic. The pointer advance and counter clear are registered
  // on entry to YIELD, so the YIELD cycle (grant already dropped) can
  // arbitrate with the advanced pointer directly.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    ptr_next   = ptr;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_next   = pick;
          state_next = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!access || ((cnt_inc == BURST_MAX) && other_pending)) begin
          gnt_next   = '0;
          ptr_next   = owner_succ;
          cnt_next   = '0;
          state_next = ST_YIELD;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_YIELD: begin
        if (pick_valid) begin
          gnt_next   = pick;
          state_next = ST_OWN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        gnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
    // Tagged from the access cycle itself, so a grant change in the return
    // cycle cannot retarget the strobe.
    rvalid_next = active & ~I_wen;
  end

  // Output logic: AND-OR mux over the one-hot grant yields zero when idle.
  always_comb begin
    O_mem_addr  = '0;
    O_mem_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        O_mem_addr  = O_mem_addr  | I_addr[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
        O_mem_wdata = O_mem_wdata | I_wdata[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
    O_mem_wen = |(active & I_wen);
    O_gnt     = gnt;
    O_rvalid  = rvalid;
    O_rdata   = I_mem_rdata;
    O_busy    = |gnt;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural syn_mem model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req, wen;
  logic [AW-1:0]   a [N];
  logic [DW-1:0]   d [N];
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] wdata_bus;

  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wen, busy;

  always_comb begin
    addr_bus  = '0;
    wdata_bus = '0;
    for (int i = 0; i < N; i++) begin
      addr_bus[i*AW +: AW]  = a[i];
      wdata_bus[i*DW +: DW] = d[i];
    end
  end

  mem_port_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(8), .MAX_BURST(16), .BURST_CNT_WIDTH(5)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_req(req), .I_wen(wen),
    .I_addr(addr_bus), .I_wdata(wdata_bus),
    .O_gnt(gnt), .O_rvalid(rvalid), .O_rdata(rdata),
    .O_mem_addr(mem_addr), .O_mem_wen(mem_wen), .O_mem_wdata(mem_wdata),
    .I_mem_rdata(mem_rdata), .O_busy(busy)
  );

  // syn_mem model: synchronous write, 1-cycle synchronous read, bench preload.
  logic [DW-1:0] mem [32];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    else if (load_en) mem[load_addr] <= load_data;
    mem_rdata <= mem[mem_addr];
  end

  int passed = 0;
  int total  = 0;
  int viol   = 0;

  always @(negedge clk) begin
    if (rst_n && (!$onehot0(gnt) || !$onehot0(rvalid))) viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lanes_default();
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(16 + i);
      d[i] = DW'(8'h10 + i);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    wen   = '0;
    lanes_default();
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int            prime;
    logic [N-1:0]  req;
    logic [N-1:0]  wen;
    logic [N-1:0]  exp_gnt;
    logic          exp_wen;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int bad;
    int acc;
    logic [N-1:0] exp_g;

    req = '0;
    wen = '0;
    lanes_default();

    // prime = requester that owned last (pointer = prime+1), -1 = pointer 0
    vecs[0]  = '{-1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 5'd16};
    vecs[1]  = '{-1, 4'b1110, 4'b0000, 4'b0010, 1'b0, 5'd17};
    vecs[2]  = '{-1, 4'b1000, 4'b1000, 4'b1000, 1'b1, 5'd19};
    vecs[3]  = '{ 0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 5'd16};
    vecs[4]  = '{ 0, 4'b1111, 4'b0000, 4'b0010, 1'b0, 5'd17};
    vecs[5]  = '{ 1, 4'b0011, 4'b0000, 4'b0001, 1'b0, 5'd16};
    vecs[6]  = '{ 2, 4'b1100, 4'b0100, 4'b1000, 1'b0, 5'd19};
    vecs[7]  = '{ 3, 4'b1010, 4'b0010, 4'b0010, 1'b1, 5'd17};
    vecs[8]  = '{ 2, 4'b0110, 4'b0000, 4'b0010, 1'b0, 5'd17};
    vecs[9]  = '{ 1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 5'd18};
    vecs[10] = '{-1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 5'd0};

    do_reset();
    check("reset_gnt", gnt, 0);
    check("reset_busy", busy, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_mem_addr", mem_addr, 0);

    for (int v = 0; v < 11; v++) begin
      do_reset();
      if (vecs[v].prime >= 0) begin
        req = N'(1 << vecs[v].prime);
        step();
        req = '0;
        step();
        step();
      end
      req = vecs[v].req;
      wen = vecs[v].wen;
      step();
      check($sformatf("vec%0d_gnt", v), gnt, vecs[v].exp_gnt);
      check($sformatf("vec%0d_busy", v), busy, (vecs[v].exp_gnt != 0));
      check($sformatf("vec%0d_mem_wen", v), mem_wen, vecs[v].exp_wen);
      check($sformatf("vec%0d_mem_addr", v), mem_addr, vecs[v].exp_addr);
    end

    // Reset mid-burst, then release with requests pending from pointer 0.
    do_reset();
    a[REQ_ENC] = 5'd5;
    d[REQ_ENC] = 8'h77;
    wen = 4'b0010;
    req = 4'b0010;
    step();
    step();
    check("rst_mid_pre_wen", mem_wen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_gnt", gnt, 0);
    check("rst_mid_mem_wen", mem_wen, 0);
    check("rst_mid_rvalid", rvalid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    req = 4'b1010;
    wen = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_rel_gnt", gnt, 4'b0010);
    check("rst_rel_rvalid", rvalid, 0);

    // Single read from addr 3 holding A5.
    do_reset();
    load_en = 1'b1; load_addr = 5'd3; load_data = 8'hA5;
    step();
    load_en = 1'b0;
    a[REQ_MEAS] = 5'd3;
    req = 4'b0001;
    step();
    check("rd_gnt", gnt, 4'b0001);
    check("rd_mem_addr", mem_addr, 3);
    check("rd_mem_wen", mem_wen, 0);
    check("rd_rvalid_early", rvalid, 0);
    step();
    check("rd_rvalid", rvalid, 4'b0001);
    check("rd_rdata", rdata, 8'hA5);
    req = '0;
    step();
    check("rd_rvalid_off", rvalid, 0);
    check("rd_gnt_off", gnt, 0);

    // Contention: three requesters, 16-cycle bursts separated by one bubble.
    do_reset();
    req = 4'b0111;
    for (int s = 1; s <= 50; s++) begin
      step();
      exp_g = (((s - 1) % 17) == 16) ? 4'b0000 : N'(1 << ((s - 1) / 17));
      check($sformatf("cont_gnt_c%0d", s), gnt, exp_g);
    end

    // Release handover 2 -> 3 with one bubble, then pointer wrap to 0.
    do_reset();
    req = 4'b1100;
    step(); step(); step(); step();
    check("ho_gnt2", gnt, 4'b0100);
    req = 4'b1000;
    step();
    check("ho_bubble", gnt, 0);
    step();
    check("ho_gnt3", gnt, 4'b1000);
    req = 4'b0011;
    step();
    check("ho_bubble2", gnt, 0);
    step();
    check("ho_wrap_gnt0", gnt, 4'b0001);

    // Write then read back through a different requester.
    do_reset();
    a[REQ_ENC] = 5'd9;
    d[REQ_ENC] = 8'h3C;
    wen = 4'b0010;
    req = 4'b0010;
    step();
    check("wr_gnt", gnt, 4'b0010);
    check("wr_mem_wen", mem_wen, 1);
    check("wr_mem_addr", mem_addr, 9);
    check("wr_mem_wdata", mem_wdata, 8'h3C);
    step();
    req = 4'b0100;
    wen = '0;
    a[REQ_DEC] = 5'd9;
    step();
    step();
    check("rb_gnt", gnt, 4'b0100);
    check("rb_mem_addr", mem_addr, 9);
    step();
    check("rb_rvalid", rvalid, 4'b0100);
    check("rb_rdata", rdata, 8'h3C);

    // Lone requester: unbroken burst, then yield once a rival appears.
    do_reset();
    req = 4'b1000;
    bad = 0;
    acc = 0;
    for (int s = 1; s <= 50; s++) begin
      step();
      if (gnt !== 4'b1000) bad++;
      if ((gnt & req) != 0) acc++;
    end
    check("lone_gnt_breaks", bad, 0);
    check("lone_accesses", acc, 50);
    req = 4'b1001;
    step();
    check("lone_sat_yield", gnt, 0);
    step();
    check("lone_next_gnt0", gnt, 4'b0001);

    check("onehot_violations", viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
